// File: rtl/meas_sequencer.sv
// Gated frequency-measurement sequencer: clear, gate, settle, latch, present; optional MEAS_TIMEOUT_EN drops unaccepted results.
// First result_valid_out GATE_CYCLES+SETTLE_CYCLES+3 cycles after start; PRESENT holds until result_ready_in (or timeout).
module meas_sequencer #(
  parameter int unsigned GATE_CYCLES    = 1000000,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic             clk_ref_in,
  input  logic             reset_n_in,
  input  logic             start_in,
  output logic             cnt_clear_out,
  output logic             cnt_enable_out,
  input  logic [CNT_W-1:0] cnt_value_in,
  output logic [CNT_W-1:0] result_out,
  output logic             overflow_out,
  output logic             result_valid_out,
  input  logic             result_ready_in,
  output logic             busy_out,
  output logic             dropped_out
);

  localparam int unsigned GATE_W   = $clog2(GATE_CYCLES + 1);
  localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [GATE_W-1:0]   GATE_LAST   = GATE_W'(GATE_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  if (GATE_CYCLES < 1) begin : g_bad_gate
    $error("GATE_CYCLES must be >= 1");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    GATE,
    SETTLE,
    LATCH,
    PRESENT
  } state_t;

  state_t              state;
  logic [GATE_W-1:0]   gate_cnt;
  logic [SETTLE_W-1:0] settle_cnt;

`ifdef MEAS_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt;
`else
  assign dropped_out = 1'b0;
`endif

  always_ff @(posedge clk_ref_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state            <= IDLE;
      gate_cnt         <= '0;
      settle_cnt       <= '0;
      cnt_clear_out    <= 1'b0;
      cnt_enable_out   <= 1'b0;
      result_out       <= '0;
      overflow_out     <= 1'b0;
      result_valid_out <= 1'b0;
      busy_out         <= 1'b0;
`ifdef MEAS_TIMEOUT_EN
      to_cnt           <= '0;
      dropped_out      <= 1'b0;
`endif
    end else begin
      cnt_clear_out <= 1'b0;
`ifdef MEAS_TIMEOUT_EN
      dropped_out   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start_in) begin
            state         <= CLEAR;
            cnt_clear_out <= 1'b1;
            busy_out      <= 1'b1;
          end
        end
        CLEAR: begin
          state          <= GATE;
          gate_cnt       <= '0;
          cnt_enable_out <= 1'b1;
        end
        GATE: begin
          if (gate_cnt == GATE_LAST) begin
            state          <= SETTLE;
            gate_cnt       <= '0;
            settle_cnt     <= '0;
            cnt_enable_out <= 1'b0;
          end else begin
            gate_cnt <= gate_cnt + 1'b1;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state      <= LATCH;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        LATCH: begin
          result_out       <= cnt_value_in;
          overflow_out     <= &cnt_value_in;
          result_valid_out <= 1'b1;
          state            <= PRESENT;
`ifdef MEAS_TIMEOUT_EN
          to_cnt           <= '0;
`endif
        end
        PRESENT: begin
          // A transfer in the final timeout cycle wins over the drop.
          if (result_ready_in) begin
            result_valid_out <= 1'b0;
            if (start_in) begin
              state         <= CLEAR;
              cnt_clear_out <= 1'b1;
            end else begin
              state    <= IDLE;
              busy_out <= 1'b0;
            end
`ifdef MEAS_TIMEOUT_EN
          end else if (to_cnt == TO_LAST) begin
            result_valid_out <= 1'b0;
            dropped_out      <= 1'b1;
            to_cnt           <= '0;
            if (start_in) begin
              state         <= CLEAR;
              cnt_clear_out <= 1'b1;
            end else begin
              state    <= IDLE;
              busy_out <= 1'b0;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
`endif
          end
        end
        default: begin
          state            <= IDLE;
          cnt_enable_out   <= 1'b0;
          result_valid_out <= 1'b0;
          busy_out         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_meas_sequencer.sv
// Randomized bench for meas_sequencer against a timeline model: each measurement is a cycle index since start.
// Honours MEAS_TIMEOUT_EN when the bundle is built with it.
module tb_meas_sequencer;
  localparam int G  = 10;
  localparam int S  = 4;
  localparam int TO = 8;
  localparam int P  = G + S + 3;  // measurement cycle index of the first PRESENT cycle

  logic        clk_ref_in = 1'b0;
  logic        reset_n_in;
  logic        start_in;
  logic        cnt_clear_out;
  logic        cnt_enable_out;
  logic [31:0] cnt_value_in;
  logic [31:0] result_out;
  logic        overflow_out;
  logic        result_valid_out;
  logic        result_ready_in;
  logic        busy_out;
  logic        dropped_out;

  meas_sequencer #(
    .GATE_CYCLES   (G),
    .SETTLE_CYCLES (S),
    .CNT_W         (32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_ref_in      (clk_ref_in),
    .reset_n_in      (reset_n_in),
    .start_in        (start_in),
    .cnt_clear_out   (cnt_clear_out),
    .cnt_enable_out  (cnt_enable_out),
    .cnt_value_in    (cnt_value_in),
    .result_out      (result_out),
    .overflow_out    (overflow_out),
    .result_valid_out(result_valid_out),
    .result_ready_in (result_ready_in),
    .busy_out        (busy_out),
    .dropped_out     (dropped_out)
  );

  always #5 clk_ref_in = ~clk_ref_in;

  int checks = 0;
  int errors = 0;

  // Model: m_e = 1 is the clear cycle, 2..G+1 gate, P-1 latch, >= P presenting.
  bit          m_act  = 1'b0;
  int          m_e    = 0;
  logic [31:0] m_res  = '0;
  bit          m_ovf  = 1'b0;
  bit          m_drop = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("clear",    32'(cnt_clear_out),    32'(m_act && m_e == 1));
    check("enable",   32'(cnt_enable_out),   32'(m_act && m_e >= 2 && m_e <= G + 1));
    check("valid",    32'(result_valid_out), 32'(m_act && m_e >= P));
    check("busy",     32'(busy_out),         32'(m_act));
    check("result",   result_out,            m_res);
    check("overflow", 32'(overflow_out),     32'(m_ovf));
    check("dropped",  32'(dropped_out),      32'(m_drop));
  endtask

  task automatic model_next();
    bit leave;
    m_drop = 1'b0;
    if (!reset_n_in) begin
      m_act = 1'b0; m_e = 0; m_res = '0; m_ovf = 1'b0;
    end else if (!m_act) begin
      if (start_in) begin
        m_act = 1'b1; m_e = 1;
      end
    end else if (m_e < P) begin
      if (m_e == P - 1) begin
        m_res = cnt_value_in;
        m_ovf = (cnt_value_in == 32'hFFFF_FFFF);
      end
      m_e++;
    end else begin
      leave = result_ready_in;
`ifdef MEAS_TIMEOUT_EN
      if (!leave && (m_e - P + 1) == TO) begin
        leave  = 1'b1;
        m_drop = 1'b1;
      end
`endif
      if (leave) begin
        if (start_in) m_e = 1;
        else begin
          m_act = 1'b0; m_e = 0;
        end
      end else begin
        m_e++;
      end
    end
  endtask

  task automatic cycle(input bit s, input bit r, input logic [31:0] v);
    start_in        = s;
    result_ready_in = r;
    cnt_value_in    = v;
    model_next();
    @(posedge clk_ref_in);
    #1;
    check_outputs();
  endtask

  function automatic logic [31:0] rand_val(input int ones_pct);
    logic [31:0] v;
    v = (int'($urandom_range(99)) < ones_pct) ? 32'hFFFF_FFFF : 32'($urandom);
    return v;
  endfunction

  task automatic random_phase(input int n, input int sp, input int rp, input int op);
    for (int i = 0; i < n; i++)
      cycle(int'($urandom_range(99)) < sp, int'($urandom_range(99)) < rp, rand_val(op));
  endtask

  initial begin
    int  n;
    int  last;
    bit  seen;

    reset_n_in      = 1'b0;
    start_in        = 1'b0;
    result_ready_in = 1'b0;
    cnt_value_in    = '0;
    repeat (3) @(posedge clk_ref_in);
    #1;
    check_outputs();
    reset_n_in = 1'b1;

    // Single start pulse: latency and captured value.
    cycle(1'b1, 1'b1, 32'd1234);
    n    = 1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cycle(1'b0, 1'b1, 32'd1234);
      n++;
      if (result_valid_out) seen = 1'b1;
    end
    check("latency", 32'(n), 32'(P));
    check("result_1234", result_out, 32'd1234);
    random_phase(5, 0, 50, 0);

    // Start held with ready high: one result every P cycles.
    last = -1;
    for (int i = 0; i < 4 * P; i++) begin
      cycle(1'b1, 1'b1, rand_val(40));
      if (result_valid_out) begin
        if (last >= 0) check("period", 32'(i - last), 32'(P));
        last = i;
      end
    end

    // Stall in PRESENT with ready low for 50 cycles, then accept.
    for (int i = 0; i < 200 && !(m_act && m_e == P); i++) cycle(1'b1, 1'b0, rand_val(30));
    repeat (50) cycle(1'b0, 1'b0, 32'($urandom));
    cycle(1'b0, 1'b1, 32'($urandom));

    random_phase(400, 30, 40, 20);
    random_phase(300, 80, 10, 30);
    random_phase(300, 10, 90, 20);

    // Asynchronous reset in the sixth gate cycle.
    for (int i = 0; i < 200 && !(m_act && m_e == 7); i++) cycle(1'b1, 1'b1, 32'($urandom));
    #2;
    reset_n_in = 1'b0;
    #1;
    check("rst_clear",    32'(cnt_clear_out),    32'd0);
    check("rst_enable",   32'(cnt_enable_out),   32'd0);
    check("rst_valid",    32'(result_valid_out), 32'd0);
    check("rst_busy",     32'(busy_out),         32'd0);
    check("rst_result",   result_out,            32'd0);
    check("rst_overflow", 32'(overflow_out),     32'd0);
    check("rst_dropped",  32'(dropped_out),      32'd0);
    m_act = 1'b0; m_e = 0; m_res = '0; m_ovf = 1'b0; m_drop = 1'b0;
    repeat (2) cycle(1'b1, 1'b1, 32'($urandom));
    reset_n_in = 1'b1;
    random_phase(30, 0, 50, 0);

    random_phase(300, 50, 50, 25);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
